tx_block: RTL and testbench
===========================

Name: tx_block

Overview:
UART-style serial transmitter; upstream counterpart of the receiver (rcv_block), driving its serial_in line. Accepts parallel bytes through a one-entry holding buffer and serialises them as 8N1 frames: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Double buffering (holding register plus shift register) allows back-to-back frames with no idle gap.

Parameters:
CLKS_PER_BIT, 10, clock cycles per serial bit; legal values are 2 or more.

Ports:
clk  input  1  system clock, rising-edge active
n_rst  input  1  asynchronous, active-low reset
tx_data  input  8  byte to transmit; sampled when a load is accepted
data_load  input  1  load strobe; accepted only at an edge where buffer_empty=1
serial_out  output  1  serial line, registered; idles high
buffer_empty  output  1  1 = holding register free to accept a byte
tx_busy  output  1  1 = frame in progress (state != IDLE)
load_error  output  1  one-cycle pulse: data_load asserted while buffer_empty=0

Behaviour:
- Reset (asynchronous, n_rst=0):
  - serial_out=1, buffer_empty=1, tx_busy=0, load_error=0.
  - State=IDLE; bit counter and cycle counter=0.
  - Holding and shift registers=0.
- All outputs are registered; no combinational input-to-output paths.
- Load handshake:
  - At an edge with data_load=1 and buffer_empty=1: hold_reg<=tx_data, buffer_empty<=0.
  - At an edge with data_load=1 and buffer_empty=0: hold_reg unchanged; load_error<=1 for exactly one cycle.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE:
    - Entered with buffer_empty=0 -> next edge: shift_reg<=hold_reg, buffer_empty<=1, serial_out<=0, state<=START, counters cleared.
    - Otherwise serial_out stays 1.
  - START: hold serial_out=0 for CLKS_PER_BIT cycles. At the last cycle: serial_out<=shift_reg[0], state<=DATA, bit_cnt<=0.
  - DATA:
    - Each bit is held CLKS_PER_BIT cycles.
    - At the end of each bit: shift right and present the next LSB.
    - After bit 7 completes: serial_out<=1, state<=STOP.
  - STOP: hold serial_out=1 for CLKS_PER_BIT cycles. At the last cycle:
    - If buffer_empty=0: transfer hold->shift, buffer_empty<=1, serial_out<=0, state<=START (no idle cycle).
    - Else: state<=IDLE.
- Latency:
  - serial_out falls at the edge one cycle after the load-accept edge.
  - A frame is exactly 10*CLKS_PER_BIT cycles long.
- Boundary conditions:
  - A load accepted during any frame state fills the holding register for the next frame. A second load before that transfer -> load_error, first byte kept.
  - data_load at the same edge as a hold->shift transfer:
    - buffer_empty was 0 going into that edge, so the load is rejected with load_error.
    - The byte presented at that edge is not captured.
  - tx_data changes while not loading are ignored; the shift register is independent of tx_data.
  - Cycle counter width is clog2(CLKS_PER_BIT). Bit counter is 3 bits and wraps at 7 only via the state transition; it never free-runs.
  - Reset mid-frame: the frame is abandoned, serial_out returns to 1 immediately (asynchronously), and the buffered byte is discarded.
- tx_busy=1 in START/DATA/STOP, 0 in IDLE. It stays 1 continuously across back-to-back frames.

Test Plan:
- Reset: assert n_rst=0 mid-cycle -> serial_out=1, buffer_empty=1, tx_busy=0, load_error=0 without waiting for a clock edge.
- Single byte, CLKS_PER_BIT=10: load 0xA5 -> serial_out sequence 0,1,0,1,0,0,1,0,1,1, each level held 10 cycles.
  - Falling edge one cycle after the load edge.
  - tx_busy high 100 cycles, then IDLE.
- Back-to-back: load 0x00, then load 0xFF once buffer_empty returns to 1.
  - 200 contiguous cycles: 0,0x8,1,0,1x8,1, each held 10 cycles, with no extra idle cycle between the frames.
  - tx_busy never drops between frames.
- Overload: load 0x3C, then load 0x11 while buffer_empty=0 -> load_error pulses high for 1 cycle; the second transmitted byte is 0x3C's successor only if it was accepted, and 0x11 never appears on the line.
- Reset mid-frame: assert n_rst at cycle 45 of a 0x55 frame -> serial_out=1 immediately.
  - After release, a subsequent load of 0x0F transmits a clean frame 0,1,1,1,1,0,0,0,0,1.
- Loopback: serial_out wired to rcv_block serial_in, send bytes 0x00, 0xFF, 0xA5, 0x5A -> receiver reports identical rx_data with framing_error=0 for each.

Source files
------------

// File: rtl/tx_block.sv
// UART-style 8N1 serial transmitter with a one-entry holding buffer in front of
// the shift register, so frames can run back to back without an idle gap.
module tx_block #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [7:0] tx_data,
    input  logic       data_load,
    output logic       serial_out,
    output logic       buffer_empty,
    output logic       tx_busy,
    output logic       load_error
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state, state_n;
    logic [CW-1:0] cyc_cnt, cyc_n;
    logic [2:0]  bit_cnt, bit_n;
    logic [7:0]  hold_reg, hold_n;
    logic [7:0]  shift_reg, shift_n;
    logic        serial_n, empty_n, busy_n, err_n;
    logic        start_frame;
    logic        cyc_last;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= IDLE;
            cyc_cnt      <= '0;
            bit_cnt      <= '0;
            hold_reg     <= '0;
            shift_reg    <= '0;
            serial_out   <= 1'b1;
            buffer_empty <= 1'b1;
            tx_busy      <= 1'b0;
            load_error   <= 1'b0;
        end else begin
            state        <= state_n;
            cyc_cnt      <= cyc_n;
            bit_cnt      <= bit_n;
            hold_reg     <= hold_n;
            shift_reg    <= shift_n;
            serial_out   <= serial_n;
            buffer_empty <= empty_n;
            tx_busy      <= busy_n;
            load_error   <= err_n;
        end
    end

    always_comb begin
        state_n     = state;
        cyc_n       = cyc_cnt;
        bit_n       = bit_cnt;
        hold_n      = hold_reg;
        shift_n     = shift_reg;
        serial_n    = serial_out;
        empty_n     = buffer_empty;
        err_n       = 1'b0;
        start_frame = 1'b0;
        cyc_last    = (cyc_cnt == LAST);

        if (data_load) begin
            if (buffer_empty) begin
                hold_n  = tx_data;
                empty_n = 1'b0;
            end else begin
                err_n = 1'b1;
            end
        end

        case (state)
            IDLE: begin
                serial_n = 1'b1;
                if (!buffer_empty) start_frame = 1'b1;
            end
            START: begin
                if (cyc_last) begin
                    cyc_n    = '0;
                    bit_n    = '0;
                    serial_n = shift_reg[0];
                    state_n  = DATA;
                end else begin
                    cyc_n = cyc_cnt + 1'b1;
                end
            end
            DATA: begin
                if (cyc_last) begin
                    cyc_n = '0;
                    if (bit_cnt == 3'd7) begin
                        serial_n = 1'b1;
                        state_n  = STOP;
                    end else begin
                        shift_n  = shift_reg >> 1;
                        serial_n = shift_reg[1];
                        bit_n    = bit_cnt + 3'd1;
                    end
                end else begin
                    cyc_n = cyc_cnt + 1'b1;
                end
            end
            STOP: begin
                if (cyc_last) begin
                    cyc_n = '0;
                    if (!buffer_empty) start_frame = 1'b1;
                    else               state_n     = IDLE;
                end else begin
                    cyc_n = cyc_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        // Transfer only happens with buffer_empty=0, so it never collides with an accepted load.
        if (start_frame) begin
            shift_n  = hold_reg;
            empty_n  = 1'b1;
            serial_n = 1'b0;
            state_n  = START;
            cyc_n    = '0;
            bit_n    = '0;
        end

        busy_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_tx_block.sv
// Randomized and directed bench for tx_block: a cycle-count frame model predicts
// every output each cycle, and a sampling receiver decodes the line.
module tb_tx_block;

    localparam int C = 10;

    logic       clk = 1'b0;
    logic       n_rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       data_load = 1'b0;
    logic       serial_out, buffer_empty, tx_busy, load_error;

    tx_block #(.CLKS_PER_BIT(C)) dut (
        .clk(clk), .n_rst(n_rst), .tx_data(tx_data), .data_load(data_load),
        .serial_out(serial_out), .buffer_empty(buffer_empty),
        .tx_busy(tx_busy), .load_error(load_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Frame model: a frame is 10*C cycles; position within it selects the line level.
    bit         m_active = 0;
    int         m_pos = 0;
    logic [7:0] m_frame = '0;
    logic [7:0] m_hold = '0;
    bit         m_hold_full = 0;
    bit         m_err = 0;
    logic [7:0] exp_q[$];

    bit         rx_on = 0;
    int         rx_cnt = 0;
    logic [7:0] rx_b = '0;

    int busy_run = 0;
    int last_run = 0;

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
    endfunction

    function automatic logic exp_line();
        return m_active ? frame_bit(m_frame, m_pos / C) : 1'b1;
    endfunction

    task automatic model_reset();
        m_active = 0; m_pos = 0; m_hold_full = 0; m_err = 0; m_hold = '0;
        rx_on = 0; rx_cnt = 0;
        busy_run = 0;
        exp_q.delete();
    endtask

    task automatic rx_step(input logic line);
        int k;
        if (!rx_on) begin
            if (line == 1'b0) begin
                rx_on = 1; rx_cnt = 0;
            end
        end else begin
            rx_cnt++;
        end
        if (rx_on && (rx_cnt % C) == C / 2) begin
            k = rx_cnt / C;
            if (k == 0) begin
                check("rx_start_bit", line, 1'b0);
            end else if (k <= 8) begin
                rx_b[k-1] = line;
            end else begin
                check("rx_stop_bit", line, 1'b1);
                if (exp_q.size() == 0) check("rx_unexpected_frame", 32'(exp_q.size()), 1);
                else check("rx_byte", rx_b, exp_q.pop_front());
                rx_on = 0;
            end
        end
    endtask

    task automatic tick();
        bit hf;
        @(posedge clk);
        hf = m_hold_full;
        if (m_active) begin
            m_pos++;
            if (m_pos == 10 * C) m_active = 0;
        end
        if (!m_active && hf) begin
            m_active = 1; m_pos = 0; m_frame = m_hold; m_hold_full = 0;
            exp_q.push_back(m_hold);
        end
        m_err = data_load && hf;
        if (data_load && !hf) begin
            m_hold = tx_data; m_hold_full = 1;
        end
        #1;
        check("serial_out", serial_out, exp_line());
        check("buffer_empty", buffer_empty, !m_hold_full);
        check("tx_busy", tx_busy, m_active);
        check("load_error", load_error, m_err);
        rx_step(serial_out);
        if (tx_busy) busy_run++;
        else if (busy_run > 0) begin
            last_run = busy_run; busy_run = 0;
        end
    endtask

    task automatic load_byte(input logic [7:0] b);
        int n = 0;
        while (!buffer_empty && n < 2000) begin
            tick(); n++;
        end
        check("load_wait_done", buffer_empty, 1'b1);
        tx_data = b; data_load = 1'b1;
        tick();
        data_load = 1'b0; tx_data = 8'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        data_load = 1'b0;
        while ((tx_busy || !buffer_empty) && n < 3000) begin
            tick(); n++;
        end
        tick();
        check("drain_idle", tx_busy, 1'b0);
        check("drain_rx_queue", 32'(exp_q.size()), 0);
    endtask

    initial begin
        // Asynchronous reset before any clock edge.
        #1 n_rst = 1'b0;
        #1;
        check("rst_serial_out", serial_out, 1'b1);
        check("rst_buffer_empty", buffer_empty, 1'b1);
        check("rst_tx_busy", tx_busy, 1'b0);
        check("rst_load_error", load_error, 1'b0);
        #10 n_rst = 1'b1;
        repeat (3) tick();

        // Single byte 0xA5.
        load_byte(8'hA5);
        tick();
        check("start_latency", serial_out, 1'b0);
        drain();
        check("single_busy_len", 32'(last_run), 100);

        // Back-to-back 0x00 then 0xFF: busy must stay high for both frames.
        load_byte(8'h00);
        load_byte(8'hFF);
        drain();
        check("b2b_busy_len", 32'(last_run), 200);

        // Overload: load at the transfer edge is rejected, second load mid-frame accepted.
        load_byte(8'h3C);
        tx_data = 8'h11; data_load = 1'b1;
        tick();
        data_load = 1'b0;
        check("overload_err", load_error, 1'b1);
        tick();
        check("overload_err_pulse", load_error, 1'b0);
        repeat (20) tick();
        load_byte(8'h42);
        tx_data = 8'h99; data_load = 1'b1;
        tick();
        data_load = 1'b0;
        check("overload_err2", load_error, 1'b1);
        drain();

        // Reset at cycle 45 of a 0x55 frame.
        load_byte(8'h55);
        repeat (45) tick();
        #2 n_rst = 1'b0;
        #1;
        check("midrst_serial_out", serial_out, 1'b1);
        check("midrst_tx_busy", tx_busy, 1'b0);
        check("midrst_buffer_empty", buffer_empty, 1'b1);
        model_reset();
        n_rst = 1'b1;
        repeat (2) tick();
        load_byte(8'h0F);
        drain();

        // Stream for the loopback receiver.
        load_byte(8'h00);
        load_byte(8'hFF);
        load_byte(8'hA5);
        load_byte(8'h5A);
        drain();

        // Random loads and data noise.
        for (int i = 0; i < 4000; i++) begin
            data_load = (($urandom % 16) == 0);
            tx_data = 8'($urandom);
            tick();
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
